// File: rtl/arm_pkg.sv
// Shared decode definitions for the ARM decode stage: instruction modes,
// data-processing opcodes, ALU command encoding and the control bundle.
package arm_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  typedef enum logic [3:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_t;

  // Compare/test and memory address generation reuse the arithmetic/logic commands.
  localparam exe_cmd_t EXE_CMP  = EXE_SUB;
  localparam exe_cmd_t EXE_TST  = EXE_AND;
  localparam exe_cmd_t EXE_LDST = EXE_ADD;

  typedef struct packed {
    exe_cmd_t exe_cmd;
    logic     wb_en;
    logic     mem_r;
    logic     mem_w;
    logic     b;
    logic     s;
    logic     imm;
  } ctrl_t;

  function automatic exe_cmd_t dp_cmd(input logic [3:0] op);
    case (op)
      OP_MOV:  dp_cmd = EXE_MOV;
      OP_MVN:  dp_cmd = EXE_MVN;
      OP_ADD:  dp_cmd = EXE_ADD;
      OP_ADC:  dp_cmd = EXE_ADC;
      OP_SUB:  dp_cmd = EXE_SUB;
      OP_SBC:  dp_cmd = EXE_SBC;
      OP_AND:  dp_cmd = EXE_AND;
      OP_ORR:  dp_cmd = EXE_ORR;
      OP_EOR:  dp_cmd = EXE_EOR;
      OP_CMP:  dp_cmd = EXE_CMP;
      OP_TST:  dp_cmd = EXE_TST;
      default: dp_cmd = EXE_NOP;
    endcase
  endfunction

endpackage

// File: rtl/id_control_decode.sv
// Combinational instruction-field decode: control bundle, source-register use
// and the port-B read address (Rd for stores so the store data is fetched).
module id_control_decode
  import arm_pkg::*;
#(
  parameter int RADDR = 4
) (
  input  logic [1:0]       i_mode,
  input  logic             i_imm,
  input  logic [3:0]       i_opcode,
  input  logic             i_s,
  input  logic [RADDR-1:0] i_rd,
  input  logic [RADDR-1:0] i_rm,
  output ctrl_t            o_ctrl,
  output logic             o_uses_rn,
  output logic             o_uses_rm,
  output logic [RADDR-1:0] o_rm_addr
);

  always_comb begin
    o_ctrl    = '0;
    o_uses_rn = 1'b0;
    o_uses_rm = 1'b0;
    o_rm_addr = i_rm;
    case (i_mode)
      MODE_DP: begin
        o_ctrl.exe_cmd = dp_cmd(i_opcode);
        o_ctrl.wb_en   = (i_opcode != OP_CMP) && (i_opcode != OP_TST);
        o_ctrl.s       = i_s;
        o_ctrl.imm     = i_imm;
        o_uses_rn      = (i_opcode != OP_MOV) && (i_opcode != OP_MVN);
        o_uses_rm      = ~i_imm;
      end
      MODE_MEM: begin
        // The S position is the load/store bit for memory instructions.
        o_ctrl.exe_cmd = EXE_LDST;
        o_ctrl.mem_r   = i_s;
        o_ctrl.mem_w   = ~i_s;
        o_ctrl.wb_en   = i_s;
        o_ctrl.imm     = i_imm;
        o_uses_rn      = 1'b1;
        o_uses_rm      = ~i_s;
        o_rm_addr      = i_s ? i_rm : i_rd;
      end
      MODE_BR: begin
        o_ctrl.b = 1'b1;
      end
      default: begin
        o_ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// ARM decode stage: IF/ID register, register-file read addressing, RAW hazard
// detection against EX/MEM, IF stall / bubble insertion and the ID/EX register.
module id_stage
  import arm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RADDR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             id_stall,
  input  logic             branch_taken,
  output logic [RADDR-1:0] rn_addr,
  output logic [RADDR-1:0] rm_addr,
  input  logic [XLEN-1:0]  rn_val,
  input  logic [XLEN-1:0]  rm_val,
  input  logic             ex_wb_en,
  input  logic [RADDR-1:0] ex_dest,
  input  logic             mem_wb_en,
  input  logic [RADDR-1:0] mem_dest,
  output logic             idex_valid,
  output logic [XLEN-1:0]  idex_pc,
  output logic [XLEN-1:0]  idex_rn_val,
  output logic [XLEN-1:0]  idex_rm_val,
  output logic [RADDR-1:0] idex_dest,
  output logic [3:0]       idex_exe_cmd,
  output logic             idex_wb_en,
  output logic             idex_mem_r,
  output logic             idex_mem_w,
  output logic             idex_b,
  output logic             idex_s,
  output logic             idex_imm,
  output logic [11:0]      idex_shift,
  output logic [23:0]      idex_imm24,
  output logic [3:0]       idex_cond
);

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rn_val;
    logic [XLEN-1:0]  rm_val;
    logic [RADDR-1:0] dest;
    ctrl_t            ctrl;
    logic [11:0]      shift;
    logic [23:0]      imm24;
    logic [3:0]       cond;
  } idex_t;

  logic            r_ifid_valid;
  logic [31:0]     r_ifid_instr;
  logic [XLEN-1:0] r_ifid_pc;
  idex_t           r_idex;
  idex_t           w_idex_dec;
  ctrl_t           w_ctrl;
  logic            w_uses_rn;
  logic            w_uses_rm;
  logic            w_rn_hit;
  logic            w_rm_hit;
  logic            w_hazard;

  assign rn_addr = r_ifid_instr[16 +: RADDR];

  id_control_decode #(.RADDR(RADDR)) u_decode (
    .i_mode    (r_ifid_instr[27:26]),
    .i_imm     (r_ifid_instr[25]),
    .i_opcode  (r_ifid_instr[24:21]),
    .i_s       (r_ifid_instr[20]),
    .i_rd      (r_ifid_instr[12 +: RADDR]),
    .i_rm      (r_ifid_instr[0 +: RADDR]),
    .o_ctrl    (w_ctrl),
    .o_uses_rn (w_uses_rn),
    .o_uses_rm (w_uses_rm),
    .o_rm_addr (rm_addr)
  );

  // WB is not checked: the register file writes on negedge, so a same-cycle read is already current.
  assign w_rn_hit = (ex_wb_en && (ex_dest == rn_addr)) || (mem_wb_en && (mem_dest == rn_addr));
  assign w_rm_hit = (ex_wb_en && (ex_dest == rm_addr)) || (mem_wb_en && (mem_dest == rm_addr));
  assign w_hazard = r_ifid_valid && ((w_uses_rn && w_rn_hit) || (w_uses_rm && w_rm_hit));
  assign id_stall = w_hazard && !branch_taken;

  always_comb begin
    w_idex_dec = '0;
    if (r_ifid_valid) begin
      w_idex_dec.valid  = 1'b1;
      w_idex_dec.pc     = r_ifid_pc;
      w_idex_dec.rn_val = rn_val;
      w_idex_dec.rm_val = rm_val;
      w_idex_dec.dest   = r_ifid_instr[12 +: RADDR];
      w_idex_dec.ctrl   = w_ctrl;
      w_idex_dec.shift  = r_ifid_instr[11:0];
      w_idex_dec.imm24  = r_ifid_instr[23:0];
      w_idex_dec.cond   = r_ifid_instr[31:28];
    end else begin
      w_idex_dec = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
      r_idex       <= '0;
    end else if (branch_taken) begin
      r_ifid_valid <= 1'b0;
      r_idex       <= '0;
    end else if (w_hazard) begin
      r_idex       <= '0;
    end else begin
      r_ifid_valid <= if_valid;
      r_ifid_instr <= if_instr;
      r_ifid_pc    <= if_pc;
      r_idex       <= w_idex_dec;
    end
  end

  assign idex_valid   = r_idex.valid;
  assign idex_pc      = r_idex.pc;
  assign idex_rn_val  = r_idex.rn_val;
  assign idex_rm_val  = r_idex.rm_val;
  assign idex_dest    = r_idex.dest;
  assign idex_exe_cmd = r_idex.ctrl.exe_cmd;
  assign idex_wb_en   = r_idex.ctrl.wb_en;
  assign idex_mem_r   = r_idex.ctrl.mem_r;
  assign idex_mem_w   = r_idex.ctrl.mem_w;
  assign idex_b       = r_idex.ctrl.b;
  assign idex_s       = r_idex.ctrl.s;
  assign idex_imm     = r_idex.ctrl.imm;
  assign idex_shift   = r_idex.shift;
  assign idex_imm24   = r_idex.imm24;
  assign idex_cond    = r_idex.cond;

endmodule
